// File: rtl/acc_result_buffer.sv
// Purpose : capture stage for accumulator_8bit results {ovf, carry, s} into a FWFT FIFO, with a
//           saturating overflow-event counter and a sticky lost-sample flag.
// Latency : a push at edge N is visible at o_rd_data/o_rd_valid right after edge N (empty FIFO).
// Backpr. : consumer throttles with i_rd_ready; pushes while full (no pop) are dropped and flagged.
//
// Ports:
//   i_clk, ni_rst            clock (rising edge), asynchronous active-low reset
//   i_s, i_carry, i_ovf      accumulator result sampled on i_wr_en
//   i_wr_en                  capture strobe
//   i_clr                    synchronous clear of o_ovf_cnt and o_drop (FIFO contents kept)
//   i_rd_ready               consumer accepts head entry
//   o_rd_data, o_rd_valid    head entry {ovf, carry, s} and its valid flag
//   o_full, o_empty, o_count occupancy status
//   o_ovf_cnt                saturating count of accepted pushes with ovf=1
//   o_drop                   sticky flag: a sample was lost because the FIFO was full
//
// Optional feature: define ACC_BUF_SAT_EN to store the saturated sum when ovf=1.
module acc_result_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int CW    = 8
) (
    input  logic                       i_clk,
    input  logic                       ni_rst,
    input  logic [DW-1:0]              i_s,
    input  logic                       i_carry,
    input  logic                       i_ovf,
    input  logic                       i_wr_en,
    input  logic                       i_clr,
    input  logic                       i_rd_ready,
    output logic [DW+1:0]              o_rd_data,
    output logic                       o_rd_valid,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [CW-1:0]              o_ovf_cnt,
    output logic                       o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] OVF_MAX  = '1;

    logic [DW+1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count_q;
    logic [CW-1:0] ovf_cnt_q;
    logic          drop_q;

    logic          pop;
    logic          push;
    logic          drop;
    logic [DW-1:0] wr_s;

    // Flags come from the occupancy register only, never from pointer compares.
    assign o_full     = (count_q == CNT_FULL);
    assign o_empty    = (count_q == '0);
    assign o_rd_valid = !o_empty;
    assign o_count    = count_q;
    assign o_ovf_cnt  = ovf_cnt_q;
    assign o_drop     = drop_q;

    // Memory is not reset, so the head is masked to zero while nothing valid is stored.
    assign o_rd_data  = o_empty ? '0 : mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it.
    assign pop  = o_rd_valid && i_rd_ready;
    assign push = i_wr_en && (!o_full || pop);
    assign drop = i_wr_en && o_full && !pop;

    always_comb begin
        wr_s = i_s;
`ifdef ACC_BUF_SAT_EN
        // Sign bit of the wrapped sum is the opposite of the true result's sign.
        if (i_ovf) begin
            wr_s = i_s[DW-1] ? {1'b0, {(DW-1){1'b1}}} : {1'b1, {(DW-1){1'b0}}};
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_ovf, i_carry, wr_s};
        end
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Clear takes priority over both the counter increment and a same-cycle drop.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            ovf_cnt_q <= '0;
            drop_q    <= 1'b0;
        end else if (i_clr) begin
            ovf_cnt_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            if (push && i_ovf && (ovf_cnt_q != OVF_MAX)) begin
                ovf_cnt_q <= ovf_cnt_q + CW'(1);
            end
            if (drop) begin
                drop_q <= 1'b1;
            end
        end
    end

endmodule
